// File: rtl/spart_driver_if.sv
// Control-side handshake between spart_driver and the mini-SPART.
// The shared databus is a resolved tristate net and travels as a plain inout port.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  // iocs is a one-cycle access strobe qualified by iorw/ioaddr; rda and tbr are
  // level "ready" flags from the SPART, only acted on while the driver waits on them.
  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_driver.sv
// Processor-side master for the mini-SPART: programs the baud divisor from the
// board switches, then echoes every received byte back through the transmitter.
module spart_driver (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     br_cfg,
  spart_driver_if.master bus,
  inout  wire  [7:0]     databus,
  output logic [2:0]     fsm_state
);
  localparam logic [15:0] DB_4800  = 16'h0515;
  localparam logic [15:0] DB_9600  = 16'h028A;
  localparam logic [15:0] DB_19200 = 16'h0145;
  localparam logic [15:0] DB_38400 = 16'h00A2;

  // RESET only exists while rst is low; LOAD_DBL is the state entered on the first edge.
  typedef enum logic [2:0] {RESET, LOAD_DBL, LOAD_DBH, IDLE, READ, WAIT_TBR, WRITE} state_t;

  state_t     state, next_state;
  logic [1:0] cfg_meta, sync_cfg, loaded_cfg;
  logic [7:0] rx_byte;
  logic       iocs_q, iorw_q, oe_q;
  logic [1:0] ioaddr_q;
  logic [7:0] data_q;
  logic       cs_d, rw_d, oe_d;
  logic [1:0] addr_d;
  logic [7:0] data_d;

  function automatic logic [15:0] divisor(input logic [1:0] cfg);
    case (cfg)
      2'b00:   return DB_4800;
      2'b01:   return DB_9600;
      2'b10:   return DB_19200;
      default: return DB_38400;
    endcase
  endfunction

  // Left out of reset so the switch value is already settled when rst releases.
  always_ff @(posedge clk) begin
    cfg_meta <= br_cfg;
    sync_cfg <= cfg_meta;
  end

  always_comb begin
    next_state = state;
    case (state)
      RESET:    next_state = LOAD_DBL;
      LOAD_DBL: next_state = LOAD_DBH;
      LOAD_DBH: next_state = IDLE;
      IDLE: begin
        if (sync_cfg != loaded_cfg) next_state = LOAD_DBL;
        else if (bus.rda)           next_state = READ;
      end
      READ:     next_state = WAIT_TBR;
      WAIT_TBR: if (bus.tbr) next_state = WRITE;
      WRITE:    next_state = IDLE;
      default:  next_state = LOAD_DBL;
    endcase

    // Bus outputs are those of the state being entered, so they register cleanly.
    cs_d   = 1'b0;
    rw_d   = 1'b1;
    addr_d = 2'b00;
    oe_d   = 1'b0;
    data_d = data_q;
    case (next_state)
      LOAD_DBL: begin
        cs_d = 1'b1; rw_d = 1'b0; addr_d = 2'b10; oe_d = 1'b1;
        data_d = divisor(sync_cfg)[7:0];
      end
      LOAD_DBH: begin
        cs_d = 1'b1; rw_d = 1'b0; addr_d = 2'b11; oe_d = 1'b1;
        data_d = divisor(loaded_cfg)[15:8];
      end
      READ: begin
        cs_d = 1'b1; rw_d = 1'b1; addr_d = 2'b00;
      end
      WRITE: begin
        cs_d = 1'b1; rw_d = 1'b0; addr_d = 2'b00; oe_d = 1'b1;
        data_d = rx_byte;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RESET;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= 2'b00;
      oe_q       <= 1'b0;
      data_q     <= 8'h00;
      rx_byte    <= 8'h00;
      loaded_cfg <= 2'b00;
    end else begin
      state    <= next_state;
      iocs_q   <= cs_d;
      iorw_q   <= rw_d;
      ioaddr_q <= addr_d;
      oe_q     <= oe_d;
      data_q   <= data_d;
      // Latched on entry to LOAD_DBL so both divisor bytes come from one switch value.
      if (next_state == LOAD_DBL) loaded_cfg <= sync_cfg;
      if (state == READ)          rx_byte    <= databus;
    end
  end

  assign bus.iocs   = iocs_q;
  assign bus.iorw   = iorw_q;
  assign bus.ioaddr = ioaddr_q;
  assign databus    = oe_q ? data_q : 8'hzz;
  assign fsm_state  = state;
endmodule
